// File: rtl/render_pkg.sv
// Shared constants for the rectangle renderer: screen bounds, FSM encoding
// and the counter-width helper used by the top and the scan counter.
package render_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;

  localparam int DEF_X_W   = 8;
  localparam int DEF_Y_W   = 7;
  localparam int DEF_COL_W = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // A single-pixel dimension still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Raster counter over a BOX_W x BOX_H rectangle; cx runs fastest, and
// last flags the final pixel so the owner can leave the draw state.
module rect_scan_counter
  import render_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4,
  parameter int CX_W  = cnt_w(BOX_W),
  parameter int CY_W  = cnt_w(BOX_H)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clr,
  input  logic            en,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            last
);

  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;
  logic            cx_last;

  assign cx_last = (cx_q == CX_W'(BOX_W - 1));
  assign last    = cx_last && (cy_q == CY_W'(BOX_H - 1));

  // Both counters return to zero after the last pixel so the next box
  // starts clean even when BOX_H is not a power of two.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clr) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en) begin
      if (cx_last) begin
        cx_d = '0;
        cy_d = last ? '0 : cy_q + CY_W'(1);
      end else begin
        cx_d = cx_q + CX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx = cx_q;
  assign cy = cy_q;

endmodule

// File: rtl/render_rect_datapath.sv
// Box drawing engine: latches an origin from the shared bus, then scans a
// fixed-size rectangle one pixel per clock with screen-edge clipping.
module render_rect_datapath
  import render_pkg::*;
#(
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int COL_W = DEF_COL_W,
  parameter int BOX_W = 4,
  parameter int BOX_H = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [X_W-1:0]   data_in,
  input  logic [COL_W-1:0] colour_in,
  input  logic             ld_x,
  input  logic             ld_y,
  input  logic             start_count,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] colour_out,
  output logic             plot,
  output logic             busy,
  output logic             done
);

  localparam int CX_W = cnt_w(BOX_W);
  localparam int CY_W = cnt_w(BOX_H);
  localparam logic [X_W:0] SCR_W_L = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H_L = (Y_W + 1)'(SCREEN_H);

  logic [1:0]       state_q, state_d;
  logic [X_W-1:0]   reg_x_q;
  logic [Y_W-1:0]   reg_y_q;
  logic [X_W-1:0]   bx_q;
  logic [Y_W-1:0]   by_q;
  logic [COL_W-1:0] bc_q;

  logic [CX_W-1:0]  cx;
  logic [CY_W-1:0]  cy;
  logic             last_pix;
  logic             take_start;
  logic [X_W:0]     x_sum;
  logic [Y_W:0]     y_sum;

  assign take_start = (state_q == IDLE) && start_count;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_count) state_d = DRAW;
      DRAW:    if (last_pix)    state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Origin registers load in any state; the working copies only change on
  // an accepted start, so a box in flight never sees a new origin.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      reg_x_q <= '0;
      reg_y_q <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ld_x) reg_x_q <= data_in;
      if (ld_y) reg_y_q <= data_in[Y_W-1:0];
      if (take_start) begin
        bx_q <= reg_x_q;
        by_q <= reg_y_q;
        bc_q <= colour_in;
      end
    end
  end

  rect_scan_counter #(
    .BOX_W (BOX_W),
    .BOX_H (BOX_H),
    .CX_W  (CX_W),
    .CY_W  (CY_W)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clr    (take_start),
    .en     (state_q == DRAW),
    .cx     (cx),
    .cy     (cy),
    .last   (last_pix)
  );

  // One extra bit keeps a wrapped coordinate out of the visible window.
  assign x_sum = (X_W + 1)'(bx_q) + (X_W + 1)'(cx);
  assign y_sum = (Y_W + 1)'(by_q) + (Y_W + 1)'(cy);

  assign x_out      = x_sum[X_W-1:0];
  assign y_out      = y_sum[Y_W-1:0];
  assign colour_out = bc_q;
  assign plot       = (state_q == DRAW) && (x_sum < SCR_W_L) && (y_sum < SCR_H_L);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: doc/render_rect_datapath.md
Name: render_rect_datapath

Overview:
- Drawing engine at the receiving end of the rectangle-draw control FSM.
- Loads the box origin from the shared `data_in` bus when it sees `ld_x` / `ld_y`.
- On `start_count`, scans a BOX_W x BOX_H rectangle one pixel per clock in raster order and drives VGA-adapter pixel writes (`x_out`, `y_out`, `colour_out`, `plot`).
- Reports `busy` and a one-cycle `done` so the FSM can sequence further boxes.

Parameters:
- X_W, 8, width of x coordinate
- Y_W, 7, width of y coordinate
- COL_W, 3, colour width
- BOX_W, 4, rectangle width in pixels (>=1)
- BOX_H, 4, rectangle height in pixels (>=1)
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- data_in  in  X_W  coordinate bus; low Y_W bits used for y
- colour_in  in  COL_W  fill colour, captured at start
- ld_x  in  1  load origin x register from data_in
- ld_y  in  1  load origin y register from data_in[Y_W-1:0]
- start_count  in  1  request to draw box at loaded origin
- x_out  out  X_W  current pixel x
- y_out  out  Y_W  current pixel y
- colour_out  out  COL_W  current pixel colour
- plot  out  1  pixel write strobe to VGA adapter
- busy  out  1  high while in DRAW or DONE
- done  out  1  one-cycle pulse after last pixel

Behaviour:
- Reset (async, `resetn` low): state IDLE; all origin, working and counter registers 0. Outputs `x_out`=0, `y_out`=0, `colour_out`=0, `plot`=0, `busy`=0, `done`=0. Takes effect immediately, including mid-draw.
- Load registers (`reg_x`, `reg_y`):
  - Updated on any edge where `ld_x` / `ld_y` is high, in any state.
  - They never alter a box already being drawn.
- States and transitions:
  - IDLE: on an edge with `start_count`=1, snapshot `reg_x`, `reg_y` and `colour_in` into working regs `bx`, `by`, `bc`; clear counters `cx`=0, `cy`=0; go to DRAW.
  - DRAW:
    - Each edge advances the raster: `cx`++; when `cx`==BOX_W-1, `cx`<=0 and `cy`++.
    - When `cx`==BOX_W-1 and `cy`==BOX_H-1, go to DONE.
  - DONE: one cycle, then IDLE.
- `start_count` in DRAW or DONE: ignored, not queued.
- Simultaneous load and start: the snapshot uses the pre-edge register value. The new value applies only to the next box.
- Outputs are combinational from registered state:
  - `x_out` = (`bx`+`cx`) truncated to X_W.
  - `y_out` = (`by`+`cy`) truncated to Y_W.
  - `colour_out` = `bc`.
  - `plot` = (state==DRAW) && (`bx`+`cx` < SCREEN_W) && (`by`+`cy` < SCREEN_H).
  - Sums are computed one bit wider than X_W / Y_W so wrap-around is clipped, not aliased.
- Latency:
  - The first pixel is presented in the cycle after the start edge.
  - Exactly BOX_W*BOX_H DRAW cycles follow.
  - `done`=1 in the following cycle.
  - `busy` falls with the return to IDLE.
- Clipped pixels still consume a cycle, so timing is independent of position.
- Counter widths: `$clog2(BOX_W)` and `$clog2(BOX_H)`, minimum 1 bit.

Decomposition:
- Shared package `render_pkg`:
  - SCREEN_W, SCREEN_H
  - state encoding localparams IDLE/DRAW/DONE
  - default X_W/Y_W/COL_W
- One natural sub-module: `rect_scan_counter`. It contains the parameterised `cx`/`cy` raster counter with clear, enable and last-pixel flag.
- Load registers and output logic stay in the top module.

Test Plan:
1. Reset: hold `resetn`=0 with `ld_x`/`start_count` toggling -> all outputs 0, no `plot`. Release, idle 5 cycles -> `plot`=0, `busy`=0.
2. Nominal draw: `ld_x` with `data_in`=10, `ld_y` with `data_in`=20, `colour_in`=3'b101, pulse `start_count` -> next 16 cycles `plot`=1 at (10,20),(11,20)..(13,20),(10,21)..(13,23), all `colour_out`=5. Then `done`=1 for exactly 1 cycle, `busy` high throughout.
3. Clipping: origin (158,118) -> still 16 DRAW cycles. `plot`=1 only for (158,118),(159,118),(158,119),(159,119). The other 12 cycles have `plot`=0.
4. Start and load while busy: during scenario 2 pulse `ld_x` with `data_in`=50 and `start_count` -> current box unchanged, no second box. A later start draws at x=50..53.
5. Load and start on the same edge: `reg_x`=10, then `ld_x`=1 with `data_in`=30 and `start_count`=1 together -> box drawn at x=10. The next start draws at x=30.
6. Async reset mid-draw: assert `resetn`=0 on the 7th pixel, between clock edges -> `plot`/`busy` drop immediately, no `done` pulse. After release, a start draws a full 16-pixel box.
